// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares the single-port instruction memory between the boot loader and the fetch stage
//   clk, rst                             clock and synchronous active-high reset
//   ld_req_i/ld_addr_i/ld_data_i         loader write request, held until ld_gnt_o
//   ld_done_i                            one-cycle pulse ending the program load (BOOT only)
//   ld_gnt_o                             write accepted this cycle, commits at this posedge
//   if_req_i/if_addr_i                   fetch read request, held until if_gnt_o
//   if_gnt_o                             read accepted this cycle
//   if_rvalid_o/if_rdata_o               registered read data, one cycle after if_gnt_o
//   core_hold_o                          high while in BOOT
//   im_enable_o/im_write_o/im_address_o/im_in_o  IM control, address and write data
//   im_out_i                             IM combinational read data
module im_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_done_i,
    output logic              ld_gnt_o,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              core_hold_o,
    output logic              im_enable_o,
    output logic              im_write_o,
    output logic [ADDR_W-1:0] im_address_o,
    output logic [DATA_W-1:0] im_in_o,
    input  logic [DATA_W-1:0] im_out_i
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic              core_hold_q, if_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;

    always_comb begin
        // In RUN the loader only wins against a live fetch once it has been starved long enough
        ld_gnt_o     = !rst && ld_req_i && (state_q == BOOT || !if_req_i || starve_q == LIMIT);
        if_gnt_o     = !rst && state_q == RUN && if_req_i && !ld_gnt_o;
        im_enable_o  = ld_gnt_o || if_gnt_o;
        im_write_o   = ld_gnt_o;
        im_address_o = ld_gnt_o ? ld_addr_i : if_gnt_o ? if_addr_i : '0;
        im_in_o      = ld_gnt_o ? ld_data_i : '0;
        state_d      = (state_q == BOOT && ld_done_i) ? RUN : state_q;
        starve_d     = (state_q == RUN && ld_req_i && !ld_gnt_o)
                       ? ((starve_q == LIMIT) ? starve_q : starve_q + CW'(1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            core_hold_q <= 1'b1;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            core_hold_q <= (state_d == BOOT);
            if_rvalid_q <= if_gnt_o;
            if (if_gnt_o) if_rdata_q <= im_out_i;
            starve_q    <= starve_d;
        end
    end

    assign core_hold_o = core_hold_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
endmodule

// File: tb/tb_im_port_arbiter.sv
// tb_im_port_arbiter: directed checks of boot loading, fetch, starvation guard and reset
module tb_im_port_arbiter;
    logic        clk = 0, rst = 1;
    logic        ld_req = 0, ld_done = 0, if_req = 0;
    logic [15:0] ld_addr = 0, if_addr = 0;
    logic [31:0] ld_data = 0;
    logic        ld_gnt, if_gnt, if_rvalid, core_hold, im_enable, im_write;
    logic [31:0] if_rdata, im_in, im_out;
    logic [15:0] im_address;
    logic [31:0] mem [0:255];
    int          vectors = 0, miscompares = 0, nwr = 0;

    im_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_done_i(ld_done),
        .ld_gnt_o(ld_gnt), .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .core_hold_o(core_hold),
        .im_enable_o(im_enable), .im_write_o(im_write), .im_address_o(im_address),
        .im_in_o(im_in), .im_out_i(im_out)
    );

    always #5 clk = ~clk;

    assign im_out = mem[im_address[7:0]];
    always @(posedge clk) if (im_enable && im_write) begin
        mem[im_address[7:0]] <= im_in;
        nwr <= nwr + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; ld_req = 1; if_req = 1; ld_addr = 16'h0033; ld_data = 32'h55; if_addr = 16'h0007;
        step(); step(); #1;
        vectors++; if ({ld_gnt, if_gnt, im_enable, im_write} !== 4'b0000 || im_address !== 16'h0 || im_in !== 32'h0) begin
            miscompares++; $display("FAIL reset_grants: gnt/en/wr=%b addr=%h in=%h, required 0000/0/0", {ld_gnt, if_gnt, im_enable, im_write}, im_address, im_in);
        end
        vectors++; if ({core_hold, if_rvalid} !== 2'b10 || if_rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_regs: hold,rvalid=%b rdata=%h, required 10/0", {core_hold, if_rvalid}, if_rdata);
        end
        vectors++; if (nwr !== 0) begin
            miscompares++; $display("FAIL reset_nowrite: writes=%0d, required 0", nwr);
        end
    endtask

    // T1 + T3: loader fills 0..3 while fetch is held pending in BOOT
    task automatic test_boot_load();
        step(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            ld_req = 1; ld_addr = 16'(i); ld_data = 32'hA0 + 32'(i); if_req = 1; if_addr = 16'h0002; #1;
            vectors++; if ({ld_gnt, if_gnt, im_enable, im_write, core_hold} !== 5'b10111 || im_address !== 16'(i) || im_in !== 32'hA0 + 32'(i)) begin
                miscompares++; $display("FAIL boot_write%0d: gnt/en/wr/hold=%b addr=%h in=%h, required 10111 addr=%h in=%h", i, {ld_gnt, if_gnt, im_enable, im_write, core_hold}, im_address, im_in, i, 32'hA0 + i);
            end
            step();
        end
        ld_req = 0; ld_done = 1; #1;
        vectors++; if ({ld_gnt, if_gnt, im_enable, core_hold} !== 4'b0001) begin
            miscompares++; $display("FAIL boot_done_cycle: gnt/en/hold=%b, required 0001", {ld_gnt, if_gnt, im_enable, core_hold});
        end
        step(); ld_done = 0; #1;
        vectors++; if (nwr !== 4 || mem[0] !== 32'hA0 || mem[3] !== 32'hA3) begin
            miscompares++; $display("FAIL boot_mem: writes=%0d mem0=%h mem3=%h, required 4/a0/a3", nwr, mem[0], mem[3]);
        end
        vectors++; if ({core_hold, if_gnt, im_enable, im_write} !== 4'b0110 || im_address !== 16'h0002) begin
            miscompares++; $display("FAIL run_first_fetch: hold/gnt/en/wr=%b addr=%h, required 0110/0002", {core_hold, if_gnt, im_enable, im_write}, im_address);
        end
    endtask

    // T2: fetch 2 then back-to-back 0,1
    task automatic test_back_to_back();
        logic [31:0] exp [3] = '{32'hA2, 32'hA0, 32'hA1};
        for (int i = 0; i < 3; i++) begin
            step(); if_req = (i < 2); if_addr = 16'(i); #1;
            vectors++; if (if_rvalid !== 1'b1 || if_rdata !== exp[i] || if_gnt !== (i < 2)) begin
                miscompares++; $display("FAIL fetch_b2b%0d: rvalid=%b rdata=%h gnt=%b, required 1/%h/%b", i, if_rvalid, if_rdata, if_gnt, exp[i], i < 2);
            end
        end
        step(); #1;
        vectors++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hA1) begin
            miscompares++; $display("FAIL fetch_idle: rvalid=%b rdata=%h, required 0/a1", if_rvalid, if_rdata);
        end
    endtask

    // T4: fetch gets 4 grants, loader forced in on the 5th, fetch resumes
    task automatic test_starvation();
        logic [5:0] exp_ld = 6'b010000;
        ld_req = 1; if_req = 1; ld_addr = 16'h0020; ld_data = 32'h12345678; if_addr = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++; if (ld_gnt !== exp_ld[i] || if_gnt !== !exp_ld[i]) begin
                miscompares++; $display("FAIL starve_cycle%0d: ld_gnt=%b if_gnt=%b, required %b/%b", i, ld_gnt, if_gnt, exp_ld[i], !exp_ld[i]);
            end
            step();
        end
        if_req = 0; #1;
        vectors++; if (ld_gnt !== 1'b1 || mem[8'h20] !== 32'h12345678) begin
            miscompares++; $display("FAIL starve_ld_alone: ld_gnt=%b mem20=%h, required 1/12345678", ld_gnt, mem[8'h20]);
        end
        step(); ld_req = 0; if_req = 1; if_addr = 16'h0003; step();
    endtask

    // T6: reset asserted while a loader write and a read are eligible
    task automatic test_reset_mid_run();
        rst = 1; ld_req = 1; ld_addr = 16'h0020; ld_data = 32'hFFFFFFFF; #1;
        vectors++; if ({ld_gnt, if_gnt, im_enable, im_write} !== 4'b0000 || if_rvalid !== 1'b1) begin
            miscompares++; $display("FAIL midrst_comb: gnt/en/wr=%b rvalid=%b, required 0000/1", {ld_gnt, if_gnt, im_enable, im_write}, if_rvalid);
        end
        step(); rst = 0; ld_req = 0; #1;
        vectors++; if ({core_hold, if_rvalid, if_gnt} !== 3'b100 || mem[8'h20] !== 32'h12345678) begin
            miscompares++; $display("FAIL midrst_state: hold/rvalid/gnt=%b mem20=%h, required 100/12345678", {core_hold, if_rvalid, if_gnt}, mem[8'h20]);
        end
    endtask

    // T5: write in the ld_done cycle commits, then is fetched back
    task automatic test_done_with_write();
        if_req = 0; ld_req = 1; ld_done = 1; ld_addr = 16'h0010; ld_data = 32'hDEADBEEF; #1;
        vectors++; if ({ld_gnt, im_write, core_hold} !== 3'b111 || im_address !== 16'h0010) begin
            miscompares++; $display("FAIL done_write: gnt/wr/hold=%b addr=%h, required 111/0010", {ld_gnt, im_write, core_hold}, im_address);
        end
        step(); ld_req = 0; ld_done = 0; if_req = 1; if_addr = 16'h0010; #1;
        vectors++; if ({core_hold, if_gnt} !== 2'b01) begin
            miscompares++; $display("FAIL done_run: hold/gnt=%b, required 01", {core_hold, if_gnt});
        end
        step(); if_req = 0; #1;
        vectors++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL done_readback: rvalid=%b rdata=%h, required 1/deadbeef", if_rvalid, if_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_boot_load();
        test_back_to_back();
        test_starvation();
        test_reset_mid_run();
        test_done_with_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
